// File: rtl/timer_mmss.sv
// ============================================================================
// timer_mmss -- BCD minutes:seconds countdown timer (microwave controller)
//
// Loads a cook time from keypad digits (shifted in from the right, like a
// calculator display) and counts it down while the magnetron is on.
// timer_done feeds control_mag, which stops the magnetron at 00:00; enable
// comes back from control_mag's Q.
//
// Parameters
//   TICK_DIV    clk cycles per timer second (>= 2)
//
// Ports
//   clk          in   system clock, all state on rising edge
//   reset        in   synchronous, active-high reset
//   enable       in   count enable (magnetron on)
//   clearn       in   active-low keypad CLEAR, sampled synchronously
//   digit_valid  in   one-cycle strobe, digit_in holds a new keypad digit
//   digit_in     in   [3:0] BCD keypad digit
//   min_tens     out  [3:0] minutes tens digit
//   min_ones     out  [3:0] minutes ones digit
//   sec_tens     out  [3:0] seconds tens digit
//   sec_ones     out  [3:0] seconds ones digit
//   timer_done   out  high whenever all four digits are zero
//   done_pulse   out  one-cycle pulse after a decrement lands on 00:00
// ============================================================================
module timer_mmss #(
    parameter int unsigned TICK_DIV = 10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic       clearn,
    input  logic       digit_valid,
    input  logic [3:0] digit_in,
    output logic [3:0] min_tens,
    output logic [3:0] min_ones,
    output logic [3:0] sec_tens,
    output logic [3:0] sec_ones,
    output logic       timer_done,
    output logic       done_pulse
);

    localparam int unsigned          PRESC_W    = $clog2(TICK_DIV);
    localparam logic [PRESC_W-1:0]   PRESC_LAST = PRESC_W'(TICK_DIV - 1);
    localparam logic [PRESC_W-1:0]   PRESC_ONE  = PRESC_W'(1);
    localparam logic [PRESC_W-1:0]   PRESC_ZERO = PRESC_W'(0);

    // Packed time value: {min_tens, min_ones, sec_tens, sec_ones}
    logic [15:0]        time_q;
    logic [15:0]        time_d;
    logic [PRESC_W-1:0] presc_q;
    logic [PRESC_W-1:0] presc_d;
    logic               done_pulse_q;
    logic               done_pulse_d;

    logic               count_zero_s;
    logic               entry_ok_s;
    logic               run_s;
    logic [15:0]        time_dec_s;

    // One-second BCD decrement with borrow chain. Seconds tens reload to 5
    // (a minute has 60 seconds), every other digit reloads to 9. Callers
    // never apply it at 00:00, so the min_tens wrap is unreachable.
    function automatic logic [15:0] bcd_decrement(input logic [15:0] t);
        logic [3:0] mt;
        logic [3:0] mo;
        logic [3:0] st;
        logic [3:0] so;
        mt = t[15:12];
        mo = t[11:8];
        st = t[7:4];
        so = t[3:0];
        if (so != 4'd0) begin
            so = so - 4'd1;
        end else begin
            so = 4'd9;
            if (st != 4'd0) begin
                st = st - 4'd1;
            end else begin
                st = 4'd5;
                if (mo != 4'd0) begin
                    mo = mo - 4'd1;
                end else begin
                    mo = 4'd9;
                    mt = mt - 4'd1;
                end
            end
        end
        return {mt, mo, st, so};
    endfunction

    // Decode conditions shared by the next-state logic
    always_comb begin
        count_zero_s = (time_q == 16'd0);
        // Keypad is locked while the magnetron runs; non-BCD keys are ignored
        entry_ok_s   = digit_valid && !enable && (digit_in <= 4'd9);
        run_s        = enable && !count_zero_s;
        time_dec_s   = bcd_decrement(time_q);
    end

    // Next-state: clear > digit entry > countdown > hold
    always_comb begin
        time_d       = time_q;
        presc_d      = presc_q;
        done_pulse_d = 1'b0;
        if (!clearn) begin
            time_d  = 16'd0;
            presc_d = PRESC_ZERO;
        end else if (entry_ok_s) begin
            // Shift in from the right; old min_tens falls off
            time_d  = {time_q[11:0], digit_in};
            presc_d = PRESC_ZERO;
        end else if (run_s) begin
            if (presc_q == PRESC_LAST) begin
                presc_d      = PRESC_ZERO;
                time_d       = time_dec_s;
                // Only a real decrement onto 00:00 produces the pulse
                done_pulse_d = (time_dec_s == 16'd0);
            end else begin
                presc_d = presc_q + PRESC_ONE;
            end
        end else begin
            // Paused or at 00:00: prescaler keeps its fractional second
            presc_d = presc_q;
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            time_q       <= 16'd0;
            presc_q      <= PRESC_ZERO;
            done_pulse_q <= 1'b0;
        end else begin
            time_q       <= time_d;
            presc_q      <= presc_d;
            done_pulse_q <= done_pulse_d;
        end
    end

    assign min_tens   = time_q[15:12];
    assign min_ones   = time_q[11:8];
    assign sec_tens   = time_q[7:4];
    assign sec_ones   = time_q[3:0];
    // Straight from the digit registers so control_mag sees it the same cycle
    assign timer_done = (time_q == 16'd0);
    assign done_pulse = done_pulse_q;

endmodule

// File: tb/tb_timer_mmss.sv
// Testbench for timer_mmss (TICK_DIV = 4).
// The reference model holds the display as a 4-digit decimal number and
// counts down in plain integer arithmetic; a per-cycle compare process
// checks all outputs against it, and directed literal expectations pin
// both DUT and model at the points called out in the test plan.
module tb_timer_mmss;

    localparam int TD = 4;

    logic       clk;
    logic       reset;
    logic       enable;
    logic       clearn;
    logic       digit_valid;
    logic [3:0] digit_in;
    logic [3:0] min_tens;
    logic [3:0] min_ones;
    logic [3:0] sec_tens;
    logic [3:0] sec_ones;
    logic       timer_done;
    logic       done_pulse;

    int n_checks = 0;
    int n_errors = 0;

    // Model state: display as decimal MMSS number, prescaler, pulse
    int m_val     = 0;
    int m_presc   = 0;
    bit m_pulse   = 1'b0;
    bit m_started = 1'b0;

    timer_mmss #(.TICK_DIV(TD)) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .clearn     (clearn),
        .digit_valid(digit_valid),
        .digit_in   (digit_in),
        .min_tens   (min_tens),
        .min_ones   (min_ones),
        .sec_tens   (sec_tens),
        .sec_ones   (sec_ones),
        .timer_done (timer_done),
        .done_pulse (done_pulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One second less: seconds field just drops by one, or wraps 00 -> 59
    // while minutes drop by one.
    function automatic int dec_time(input int v);
        if (v % 100 != 0) return v - 1;
        else              return v - 100 + 59;
    endfunction

    // Reference model
    always @(posedge clk) begin
        if (reset || !clearn) begin
            m_val   <= 0;
            m_presc <= 0;
            m_pulse <= 1'b0;
        end else if (digit_valid && !enable && digit_in <= 4'd9) begin
            m_val   <= (m_val * 10 + int'(digit_in)) % 10000;
            m_presc <= 0;
            m_pulse <= 1'b0;
        end else if (enable && m_val != 0) begin
            if (m_presc == TD - 1) begin
                m_presc <= 0;
                m_val   <= dec_time(m_val);
                m_pulse <= (dec_time(m_val) == 0);
            end else begin
                m_presc <= m_presc + 1;
                m_pulse <= 1'b0;
            end
        end else begin
            m_pulse <= 1'b0;
        end
        if (reset) m_started <= 1'b1;
    end

    // Per-cycle compare against the model
    always @(negedge clk) begin
        if (m_started) begin
            logic [3:0] e_mt, e_mo, e_st, e_so;
            logic       e_done;
            e_mt   = 4'(m_val / 1000);
            e_mo   = 4'((m_val / 100) % 10);
            e_st   = 4'((m_val / 10) % 10);
            e_so   = 4'(m_val % 10);
            e_done = (m_val == 0);
            n_checks++;
            if (min_tens !== e_mt || min_ones !== e_mo || sec_tens !== e_st ||
                sec_ones !== e_so || timer_done !== e_done || done_pulse !== m_pulse) begin
                n_errors++;
                $display("FAIL model_cmp @%0t: got %h%h:%h%h done=%b pulse=%b, expected %h%h:%h%h done=%b pulse=%b",
                         $time, min_tens, min_ones, sec_tens, sec_ones, timer_done, done_pulse,
                         e_mt, e_mo, e_st, e_so, e_done, m_pulse);
            end
        end
    end

    // Advance one clock edge and land on the following negedge
    task automatic step(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    task automatic press(input logic [3:0] d);
        digit_valid = 1'b1;
        digit_in    = d;
        step();
        digit_valid = 1'b0;
        digit_in    = 4'd0;
    endtask

    task automatic do_clear();
        clearn = 1'b0;
        step();
        clearn = 1'b1;
    endtask

    // Literal expectation on DUT outputs
    task automatic expect_t(input string name, input logic [15:0] t,
                            input logic done, input logic pulse);
        n_checks++;
        if ({min_tens, min_ones, sec_tens, sec_ones} !== t ||
            timer_done !== done || done_pulse !== pulse) begin
            n_errors++;
            $display("FAIL %s: got %h%h:%h%h done=%b pulse=%b, expected %h:%h done=%b pulse=%b",
                     name, min_tens, min_ones, sec_tens, sec_ones, timer_done, done_pulse,
                     t[15:8], t[7:0], done, pulse);
        end
    endtask

    initial begin
        reset       = 1'b1;
        enable      = 1'b0;
        clearn      = 1'b1;
        digit_valid = 1'b0;
        digit_in    = 4'd0;
        step(2);
        reset = 1'b0;
        step();
        expect_t("reset_state", 16'h0000, 1'b1, 1'b0);
        step(3);
        expect_t("idle", 16'h0000, 1'b1, 1'b0);

        // Keypad entry while stopped
        press(4'd1);
        expect_t("entry_1", 16'h0001, 1'b0, 1'b0);
        press(4'd2);
        expect_t("entry_12", 16'h0012, 1'b0, 1'b0);
        press(4'd3);
        press(4'd0);
        expect_t("entry_1230", 16'h1230, 1'b0, 1'b0);
        press(4'hA);
        expect_t("entry_invalid", 16'h1230, 1'b0, 1'b0);

        // Load 00:02 and run to zero
        do_clear();
        press(4'd0);
        expect_t("entry_zero_no_pulse", 16'h0000, 1'b1, 1'b0);
        press(4'd2);
        expect_t("load_0002", 16'h0002, 1'b0, 1'b0);
        enable = 1'b1;
        step(3);
        expect_t("run_3cyc", 16'h0002, 1'b0, 1'b0);
        step();
        expect_t("run_4cyc", 16'h0001, 1'b0, 1'b0);
        step(4);
        expect_t("run_8cyc_done", 16'h0000, 1'b1, 1'b1);
        step();
        expect_t("pulse_one_cycle", 16'h0000, 1'b1, 1'b0);
        step(19);
        expect_t("hold_at_zero", 16'h0000, 1'b1, 1'b0);
        enable = 1'b0;

        // Borrow chains
        do_clear();
        press(4'd1); press(4'd0); press(4'd0); press(4'd0);
        expect_t("load_1000", 16'h1000, 1'b0, 1'b0);
        enable = 1'b1;
        step(4);
        expect_t("borrow_1000", 16'h0959, 1'b0, 1'b0);
        enable = 1'b0;
        do_clear();
        press(4'd6); press(4'd0);
        enable = 1'b1;
        step(4);
        expect_t("borrow_0060", 16'h0059, 1'b0, 1'b0);
        enable = 1'b0;
        do_clear();
        press(4'd9); press(4'd9); press(4'd9); press(4'd9);
        enable = 1'b1;
        step(4);
        expect_t("max_9999", 16'h9998, 1'b0, 1'b0);
        enable = 1'b0;
        do_clear();
        press(4'd1); press(4'd0);
        enable = 1'b1;
        step(4);
        expect_t("borrow_0010", 16'h0009, 1'b0, 1'b0);
        enable = 1'b0;

        // Pause keeps the partial second; strobe while running is ignored
        do_clear();
        press(4'd5);
        enable = 1'b1;
        step(2);
        enable = 1'b0;
        step(10);
        expect_t("paused", 16'h0005, 1'b0, 1'b0);
        enable = 1'b1;
        step();
        expect_t("resume_1", 16'h0005, 1'b0, 1'b0);
        step();
        expect_t("resume_2", 16'h0004, 1'b0, 1'b0);
        press(4'd7);
        expect_t("strobe_running", 16'h0004, 1'b0, 1'b0);
        step(2);
        expect_t("strobe_kept_presc_a", 16'h0004, 1'b0, 1'b0);
        step();
        expect_t("strobe_kept_presc_b", 16'h0003, 1'b0, 1'b0);
        enable = 1'b0;

        // Clear mid-run
        do_clear();
        press(4'd3);
        enable = 1'b1;
        step(5);
        expect_t("mid_run", 16'h0002, 1'b0, 1'b0);
        do_clear();
        expect_t("clear_mid_run", 16'h0000, 1'b1, 1'b0);
        step();
        expect_t("clear_no_pulse", 16'h0000, 1'b1, 1'b0);
        enable = 1'b0;

        // Reset during entry
        press(4'd4); press(4'd5);
        expect_t("load_0045", 16'h0045, 1'b0, 1'b0);
        reset       = 1'b1;
        digit_valid = 1'b1;
        digit_in    = 4'd6;
        step();
        reset       = 1'b0;
        digit_valid = 1'b0;
        expect_t("reset_during_entry", 16'h0000, 1'b1, 1'b0);

        // Clear beats a simultaneous digit strobe
        press(4'd7);
        clearn      = 1'b0;
        digit_valid = 1'b1;
        digit_in    = 4'd8;
        step();
        clearn      = 1'b1;
        digit_valid = 1'b0;
        expect_t("clear_wins", 16'h0000, 1'b1, 1'b0);
        step(2);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
